// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency: WIDTH+1 cycles from accepted start to the done/we pulse (1 cycle on early-out paths).
// Backpressure: none; busy stalls the pipeline, and start is ignored while busy (no queueing).
// Optional feature macro: MULDIV_EARLY_OUT_EN (zero-operand multiply / zero-divisor divide skip CALC).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module muldiv_unit #(
  parameter int WIDTH = `WORD_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic             is_div;
  logic             neg_q;     // product / quotient must be negated
  logic             neg_r;     // remainder must be negated (dividend was negative)
  logic             b_zero;
  logic [WIDTH-1:0] a_raw;     // original dividend, returned as remainder on divide-by-zero
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc;       // multiply: upper partial product; divide: partial remainder
  logic [WIDTH-1:0] work;      // multiply: multiplier shifting out; divide: dividend in / quotient out
  logic [CW-1:0]    cnt;

  logic             in_signed;
  logic [WIDTH-1:0] in_mag_a;
  logic [WIDTH-1:0] in_mag_b;
  logic             early;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH-1:0]   nxt_acc;
  logic [WIDTH-1:0]   nxt_work;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign hi_we = done;
  assign lo_we = done;

  // Operand magnitudes and the early-out decision, taken straight from the inputs in IDLE.
  always_comb begin
    in_signed = ~op[0];
    in_mag_a  = (in_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    in_mag_b  = (in_signed && src_b[WIDTH-1]) ? -src_b : src_b;
`ifdef MULDIV_EARLY_OUT_EN
    early     = op[1] ? (src_b == '0) : ((src_a == '0) || (src_b == '0));
`else
    early     = 1'b0;
`endif
  end

  // One unsigned iteration of the core plus sign fix-up of the would-be final result.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, (work[0] ? mag_a : {WIDTH{1'b0}})};
    shl  = {acc, work[WIDTH-1]};
    prod = '0;
    if (is_div) begin
      // Low-bit subtraction is exact here: whenever shl >= mag_b the difference is below mag_b.
      if (shl >= {1'b0, mag_b}) begin
        nxt_acc  = shl[WIDTH-1:0] - mag_b;
        nxt_work = {work[WIDTH-2:0], 1'b1};
      end else begin
        nxt_acc  = shl[WIDTH-1:0];
        nxt_work = {work[WIDTH-2:0], 1'b0};
      end
      // Most-negative / -1 falls out naturally: magnitude quotient 0x80..0, no negation.
      if (b_zero) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = neg_r ? -nxt_acc : nxt_acc;
        res_lo = neg_q ? -nxt_work : nxt_work;
      end
    end else begin
      nxt_acc  = sum[WIDTH:1];
      nxt_work = {sum[0], work[WIDTH-1:1]};
      prod     = {nxt_acc, nxt_work};
      if (neg_q) prod = -prod;
      res_hi   = prod[2*WIDTH-1:WIDTH];
      res_lo   = prod[WIDTH-1:0];
    end
  end

  // Control FSM with registered busy/done and result words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      work   <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            is_div <= op[1];
            neg_q  <= in_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_r  <= in_signed & src_a[WIDTH-1];
            b_zero <= (src_b == '0);
            a_raw  <= src_a;
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            acc    <= '0;
            work   <= op[1] ? in_mag_a : in_mag_b;
            cnt    <= '0;
            if (early) begin
              // Zero multiply gives 0:0; zero-divisor divide gives the same words as the long path.
              state  <= DONE;
              done   <= 1'b1;
              hi_out <= op[1] ? src_a : '0;
              lo_out <= op[1] ? '1 : '0;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc  <= nxt_acc;
          work <= nxt_work;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            hi_out <= res_hi;
            lo_out <= res_lo;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
